// File: rtl/gray_fifo_wr_ctrl_if.sv
// Write-request handshake and RAM write port between the producer, the
// write-side FIFO pointer controller and the FIFO storage.
interface gray_fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  // Handshake: a write transfers on a rising edge where wr_req & wr_ready and the
  // controller is out of reset; ram_we is high exactly then, ram_waddr is the slot.
  logic                  wr_req;
  logic                  wr_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;

  modport master (output wr_req, input wr_ready, input ram_we, input ram_waddr);
  modport slave  (input wr_req, output wr_ready, output ram_we, output ram_waddr);
endinterface

// File: rtl/gray_fifo_wr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: binary write pointer,
// registered Gray export, occupancy/full flags against a synchronized read pointer.

module b2g_converter #(
  parameter int W = 5
) (
  input  logic [W-1:0] bin_val,
  output logic [W-1:0] gray_val
);
  assign gray_val = bin_val ^ (bin_val >> 1);
endmodule

module g2b_converter #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_val,
  output logic [W-1:0] bin_val
);
  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_val[i] = ^gray_val[W-1:i];
  end
endmodule

module gray_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                  clk_in,
  input  logic                  reset,
  gray_fifo_wr_ctrl_if.slave    wr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic                  ptr_error
);
  localparam int              PW      = ADDR_WIDTH + 1;
  localparam int              DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]   AF_P    = PW'(ALMOST_FULL_LVL);

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] wptr_next;
  logic [PW-1:0] wptr_next_gray;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] occ;
  logic          accept;

  b2g_converter #(.W(PW)) u_b2g (
    .bin_val  (wptr_next),
    .gray_val (wptr_next_gray)
  );

  g2b_converter #(.W(PW)) u_g2b (
    .gray_val (rptr_gray_sync),
    .bin_val  (rptr_bin)
  );

  // Occupancy is computed from the post-accept pointer so the flags already
  // account for the write landing on this edge.
  always_comb begin
    accept    = wr.wr_req & ~full & ~reset;
    wptr_next = wptr_bin + PW'(accept);
    occ       = wptr_next - rptr_bin;
  end

  assign wr.wr_ready  = ~full;
  assign wr.ram_we    = accept;
  assign wr.ram_waddr = wptr_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      ptr_error   <= 1'b0;
    end else begin
      wptr_bin    <= wptr_next;
      wptr_gray   <= wptr_next_gray;
      level       <= occ;
      // An impossible occupancy (corrupt read pointer) also blocks writes.
      full        <= (occ >= DEPTH_P);
      almost_full <= (occ >= AF_P);
      if (occ > DEPTH_P) begin
        ptr_error <= 1'b1;
      end
      if (wr.wr_req & full) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  a_no_write_when_full: assert property (@(posedge clk_in) disable iff (reset)
    full |-> !wr.ram_we);

  a_gray_holds_when_idle: assert property (@(posedge clk_in) disable iff (reset)
    !wr.ram_we |=> $stable(wptr_gray));
endmodule

// File: tb/tb_gray_fifo_wr_ctrl.sv
// Bench for gray_fifo_wr_ctrl at depth 4: directed scenarios with literal
// expectations, then random traffic checked every cycle against a counting model.
module tb_gray_fifo_wr_ctrl;
  localparam int AW    = 2;
  localparam int AFL   = 3;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_overflow = 1'b0;
  logic [AW:0]   rptr_gray_sync = '0;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   level;
  logic          almost_full;
  logic          full;
  logic          overflow;
  logic          ptr_error;

  int            tests = 0;
  int            fails = 0;
  logic [AW:0]   exp_q[$];

  // Model state: total accepted writes since reset plus the registered flags.
  int            m_w = 0;
  int            m_level = 0;
  bit            m_full = 0;
  bit            m_af = 0;
  bit            m_ovf = 0;
  bit            m_perr = 0;
  bit            m_valid = 0;

  gray_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) wr_if ();

  gray_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_LVL(AFL)) dut (
    .clk_in         (clk),
    .reset          (reset),
    .wr             (wr_if),
    .wptr_gray      (wptr_gray),
    .rptr_gray_sync (rptr_gray_sync),
    .level          (level),
    .almost_full    (almost_full),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .ptr_error      (ptr_error)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % PMOD;
  endfunction

  function automatic int from_gray(input int g);
    int b = 0;
    for (int s = 0; s <= AW; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    int occ;
    bit acc;
    bit nov;
    if (reset) begin
      m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0; m_perr = 0;
      m_valid = 1;
    end else begin
      acc = wr_if.wr_req && !m_full;
      nov = (wr_if.wr_req && m_full) ? 1'b1 : (clear_overflow ? 1'b0 : m_ovf);
      m_w = m_w + int'(acc);
      occ = (((m_w - from_gray(int'(rptr_gray_sync))) % PMOD) + PMOD) % PMOD;
      m_level = occ;
      m_full  = (occ >= DEPTH);
      m_af    = (occ >= AFL);
      if (occ > DEPTH) m_perr = 1;
      m_ovf   = nov;
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #4;
    if (m_valid) begin
      check("wptr_gray", wptr_gray, to_gray(m_w % PMOD));
      check("level", level, m_level);
      check("full", full, m_full);
      check("almost_full", almost_full, m_af);
      check("overflow", overflow, m_ovf);
      check("ptr_error", ptr_error, m_perr);
      check("wr_ready", wr_if.wr_ready, !m_full);
      check("ram_we", wr_if.ram_we, wr_if.wr_req && !m_full && !reset);
      check("ram_waddr", wr_if.ram_waddr, m_w % DEPTH);
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic drive(input logic req, input logic clr);
    wr_if.wr_req   = req;
    clear_overflow = clr;
    @(negedge clk);
  endtask

  task automatic set_rptr(input int b);
    rptr_gray_sync = (AW + 1)'(to_gray(b % PMOD));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wr_if.wr_req = 1'b0;
    clear_overflow = 1'b0;
    set_rptr(0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    wr_if.wr_req = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset(2);
    #1;
    check("rst_wptr_gray", wptr_gray, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_perr", ptr_error, 0);
    check("rst_wr_ready", wr_if.wr_ready, 1);
    @(negedge clk);

    // Fill from empty, fifth request rejected
    exp_q = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd6};
    for (int i = 0; i < 5; i++) begin
      wr_if.wr_req = 1'b1;
      #1;
      if (i < 4) check("t1_waddr", wr_if.ram_waddr, i);
      check("t1_ram_we", wr_if.ram_we, i < 4);
      @(negedge clk);
      check("t1_wgray", wptr_gray, exp_q.pop_front());
      if (i == 1) check("t1_af_lo", almost_full, 0);
      if (i == 2) check("t1_af_hi", almost_full, 1);
      if (i == 3) check("t1_full", full, 1);
    end
    wr_if.wr_req = 1'b0;
    check("t1_level", level, 4);
    check("t1_ovf", overflow, 1);
    check("t1_ready", wr_if.wr_ready, 0);

    // Read pointer advances by one
    set_rptr(1);
    drive(1'b0, 1'b0);
    check("t2_full", full, 0);
    check("t2_level", level, 3);
    check("t2_ready", wr_if.wr_ready, 1);

    // Overflow set beats clear
    drive(1'b1, 1'b0);
    check("t4_full", full, 1);
    drive(1'b1, 1'b1);
    check("t4_ovf_setwins", overflow, 1);
    drive(1'b0, 1'b1);
    check("t4_ovf_clr", overflow, 0);
    drive(1'b0, 1'b0);
    check("t4_ovf_stay", overflow, 0);

    // Reset after three writes
    do_reset(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    check("t6_level_pre", level, 3);
    reset = 1'b1;
    wr_if.wr_req = 1'b1;
    #1;
    check("t6_ram_we_rst", wr_if.ram_we, 0);
    @(negedge clk);
    check("t6_wgray", wptr_gray, 0);
    check("t6_level", level, 0);
    check("t6_full", full, 0);
    reset = 1'b0;
    wr_if.wr_req = 1'b0;

    // Corrupt read pointer ahead of write pointer
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
    check("t5_wgray", wptr_gray, 6);
    rptr_gray_sync = 3'b111;
    drive(1'b0, 1'b0);
    check("t5_perr", ptr_error, 1);
    check("t5_full", full, 1);
    check("t5_level", level, 7);
    set_rptr(4);
    drive(1'b0, 1'b0);
    check("t5_perr_sticky", ptr_error, 1);

    // Streaming with the read pointer trailing
    do_reset(1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    for (int k = 2; k < 22; k++) begin
      set_rptr(k - 1);
      drive(1'b1, 1'b0);
      check("t3_level", level, 2);
      check("t3_full", full, 0);
      check("t3_perr", ptr_error, 0);
    end
    check("t3_wgray", wptr_gray, to_gray(22 % PMOD));

    // Random traffic
    do_reset(1);
    r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        r = 0;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 2) == 0 && m_w > r) r = r + int'($urandom_range(1, m_w - r));
      end
      wr_if.wr_req   = ($urandom_range(0, 3) != 0);
      clear_overflow = ($urandom_range(0, 7) == 0);
      set_rptr(r);
      @(negedge clk);
    end
    reset = 1'b0;
    wr_if.wr_req = 1'b0;
    clear_overflow = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
